// File: rtl/wavetable_voice_mixer.sv
// wavetable_voice_mixer
// Reads one wavetable sample per active voice over a single BRAM read port,
// sums them into a widened accumulator, then scales and saturates the sum.
// One mixed sample is produced per sample tick.
//
// Ports:
//   clk_in           system clock
//   rst_in           asynchronous active-high reset
//   sample_tick_in   one-cycle pulse that starts a mix frame
//   addr_in          8 compacted voice addresses (entries 0..N-1 used)
//   num_voices_in    active voice count, clamped to 8
//   bram_addr_out    registered BRAM read address
//   bram_data_in     signed BRAM read data, BRAM_LATENCY cycles after address
//   sample_out       signed mixed sample, held between frames
//   sample_valid_out one-cycle pulse when sample_out updates
//   busy_out         high while a frame is in progress
//   overrun_out      one-cycle pulse the cycle after a dropped tick
//
// state | meaning
// IDLE  | waiting for a sample tick
// ISSUE | presenting one voice address per cycle
// DRAIN | waiting for the last read to return
// OUT   | scale, saturate and register the mixed sample
module wavetable_voice_mixer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int BRAM_LATENCY = 2,
    parameter int MIX_SHIFT    = 1
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_tick_in,
    input  logic [7:0][ADDR_WIDTH-1:0]     addr_in,
    input  logic [3:0]                     num_voices_in,
    output logic [ADDR_WIDTH-1:0]          bram_addr_out,
    input  logic signed [SAMPLE_WIDTH-1:0] bram_data_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid_out,
    output logic                           busy_out,
    output logic                           overrun_out
);

    localparam int ACC_W = SAMPLE_WIDTH + 3;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    // Tag pattern when only the final issued read is still in flight.
    localparam logic [BRAM_LATENCY-1:0] TAG_LAST = BRAM_LATENCY'(1 << (BRAM_LATENCY - 1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [7:0][ADDR_WIDTH-1:0]     addr_lat_q, addr_lat_d;
    logic [3:0]                     n_q, n_d;
    logic [2:0]                     idx_q, idx_d;
    logic [BRAM_LATENCY-1:0]        tag_q, tag_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]          bram_addr_q, bram_addr_d;
    logic signed [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                           valid_q, valid_d;
    logic                           overrun_q, overrun_d;

    logic [3:0]                     n_clamp;
    logic signed [ACC_W-1:0]        acc_shift;

    always_comb begin
        state_d     = state_q;
        addr_lat_d  = addr_lat_q;
        n_d         = n_q;
        idx_d       = idx_q;
        tag_d       = tag_q << 1;
        acc_d       = acc_q;
        bram_addr_d = bram_addr_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        overrun_d   = 1'b0;
        n_clamp     = (num_voices_in > 4'd8) ? 4'd8 : num_voices_in;
        acc_shift   = acc_q >>> MIX_SHIFT;

        // Data for a tagged address arrives as its tag leaves the pipeline.
        if (tag_q[BRAM_LATENCY-1]) begin
            acc_d = acc_q + ACC_W'(bram_data_in);
        end

        if (sample_tick_in && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_tick_in) begin
                    addr_lat_d = addr_in;
                    n_d        = n_clamp;
                    idx_d      = 3'd0;
                    acc_d      = '0;
                    if (n_clamp != 4'd0) begin
                        // Register the first address now so it is on the bus in cycle T+1.
                        bram_addr_d = addr_in[0];
                        state_d     = S_ISSUE;
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_ISSUE: begin
                tag_d[0] = 1'b1;
                if ({1'b0, idx_q} == n_q - 4'd1) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d       = idx_q + 3'd1;
                    bram_addr_d = addr_lat_q[idx_q + 3'd1];
                end
            end
            S_DRAIN: begin
                if (tag_q == TAG_LAST) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (acc_shift > SAT_MAX) begin
                    sample_d = SAT_MAX[SAMPLE_WIDTH-1:0];
                end else if (acc_shift < SAT_MIN) begin
                    sample_d = SAT_MIN[SAMPLE_WIDTH-1:0];
                end else begin
                    sample_d = acc_shift[SAMPLE_WIDTH-1:0];
                end
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            addr_lat_q  <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
            bram_addr_q <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lat_q  <= addr_lat_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            bram_addr_q <= bram_addr_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bram_addr_out    = bram_addr_q;
    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
    assign busy_out         = (state_q != S_IDLE);
    assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_wavetable_voice_mixer.sv
// Testbench for wavetable_voice_mixer: four instances with BRAM latency 1..4
// share one stimulus stream; each has its own BRAM read model over a common
// sample memory. Expected outputs come from a frame-level reference model.
module tb_wavetable_voice_mixer;

    localparam int AW    = 8;
    localparam int SW    = 16;
    localparam int SHIFT = 1;
    localparam int NI    = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   tick = 1'b0;
    logic [7:0][AW-1:0]     addr = '0;
    logic [3:0]             nv = '0;
    logic [AW-1:0]          baddr [NI];
    logic signed [SW-1:0]   samp  [NI];
    logic                   vld   [NI];
    logic                   busy  [NI];
    logic                   ovr   [NI];
    logic signed [SW-1:0]   mem   [256];
    logic [AW-1:0]          last_addr [NI];
    int                     tests = 0;
    int                     fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [AW-1:0]        pipe [g+1];
        logic signed [SW-1:0] bd;

        always @(posedge clk) begin
            pipe[0] <= baddr[g];
            for (int j = 1; j <= g; j++) pipe[j] <= pipe[j-1];
        end
        assign bd = mem[pipe[g]];

        wavetable_voice_mixer #(
            .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .BRAM_LATENCY(g + 1), .MIX_SHIFT(SHIFT)
        ) u_dut (
            .clk_in          (clk),
            .rst_in          (rst),
            .sample_tick_in  (tick),
            .addr_in         (addr),
            .num_voices_in   (nv),
            .bram_addr_out   (baddr[g]),
            .bram_data_in    (bd),
            .sample_out      (samp[g]),
            .sample_valid_out(vld[g]),
            .busy_out        (busy[g]),
            .overrun_out     (ovr[g])
        );
    end

    task automatic check_val(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Floor division by 2^SHIFT, then clip to the signed sample range.
    function automatic int mix_ref(input int sum);
        int d;
        int q;
        d = 1 << SHIFT;
        q = sum / d;
        if ((sum % d) != 0 && sum < 0) q--;
        if (q > (1 << (SW - 1)) - 1) q = (1 << (SW - 1)) - 1;
        if (q < -(1 << (SW - 1))) q = -(1 << (SW - 1));
        return q;
    endfunction

    // Starts a frame at the current negedge (cycle T) and checks every
    // instance through the valid cycle of the slowest one. Returns at that
    // negedge so the next call lands its tick in that valid cycle.
    // ovr_k > 0 drives an extra tick in cycle T+ovr_k (must be while busy).
    task automatic run_frame(input logic [7:0][AW-1:0] a, input int n_raw, input int ovr_k);
        int n;
        int sum;
        int exp_s;
        int kmax;
        int vc [NI];
        n   = (n_raw > 8) ? 8 : n_raw;
        sum = 0;
        for (int i = 0; i < n; i++) sum += int'(mem[a[i]]);
        exp_s = mix_ref(sum);
        for (int g = 0; g < NI; g++) vc[g] = (n > 0) ? n + (g + 1) + 2 : 2;
        kmax = vc[NI-1];
        addr = a;
        nv   = n_raw[3:0];
        tick = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            if (k == 1) begin
                addr = {$urandom, $urandom};
                nv   = 4'($urandom);
            end
            for (int g = 0; g < NI; g++) begin
                if (k <= n) last_addr[g] = a[k-1];
                check_val($sformatf("busy L%0d T+%0d", g + 1, k), int'(busy[g]), int'(k < vc[g]));
                check_val($sformatf("valid L%0d T+%0d", g + 1, k), int'(vld[g]), int'(k == vc[g]));
                check_val($sformatf("bram_addr L%0d T+%0d", g + 1, k), int'(baddr[g]), int'(last_addr[g]));
                check_val($sformatf("overrun L%0d T+%0d", g + 1, k), int'(ovr[g]),
                          int'(ovr_k > 0 && k == ovr_k + 1));
                if (k >= vc[g])
                    check_val($sformatf("sample L%0d n=%0d", g + 1, n_raw), int'(samp[g]), exp_s);
            end
            tick = (k == ovr_k);
        end
        tick = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < NI; g++) begin
            check_val($sformatf("%s sample L%0d", tag, g + 1), int'(samp[g]), 0);
            check_val($sformatf("%s valid L%0d", tag, g + 1), int'(vld[g]), 0);
            check_val($sformatf("%s busy L%0d", tag, g + 1), int'(busy[g]), 0);
            check_val($sformatf("%s overrun L%0d", tag, g + 1), int'(ovr[g]), 0);
            check_val($sformatf("%s bram_addr L%0d", tag, g + 1), int'(baddr[g]), 0);
        end
    endtask

    initial begin
        logic [7:0][AW-1:0] a;
        int n;
        int vc0;
        int ok;

        for (int i = 0; i < 256; i++) mem[i] = SW'($urandom);
        for (int g = 0; g < NI; g++) last_addr[g] = '0;

        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic mix: 1000 + 2000 - 500 = 2500, halved.
        a = '0;
        a[0] = 8'd10; a[1] = 8'd20; a[2] = 8'd30;
        mem[10] = 16'sd1000; mem[20] = 16'sd2000; mem[30] = -16'sd500;
        run_frame(a, 3, 0);
        @(negedge clk);

        // Asynchronous reset mid-cycle during ISSUE of an N=3 frame.
        a = '0;
        a[0] = 8'd11; a[1] = 8'd12; a[2] = 8'd13;
        addr = a; nv = 4'd3; tick = 1'b1;
        @(posedge clk);
        #2 tick = 1'b0;
        rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < NI; g++) last_addr[g] = '0;
        ok = 1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) if (vld[g] || busy[g]) ok = 0;
        end
        check_val("no_valid_after_reset", ok, 1);

        // Saturation high, saturation low, floor rounding.
        for (int i = 0; i < 8; i++) begin a[i] = AW'(40 + i); mem[40 + i] = 16'sd32767; end
        run_frame(a, 8, 0);
        for (int i = 0; i < 8; i++) begin a[i] = AW'(60 + i); mem[60 + i] = -16'sd32768; end
        run_frame(a, 8, 0);
        a = '0;
        a[0] = 8'd50; a[1] = 8'd51;
        mem[50] = -16'sd1; mem[51] = -16'sd2;
        run_frame(a, 2, 0);

        // Zero voices, clamp, single voice, overrun while busy.
        run_frame({$urandom, $urandom}, 0, 0);
        run_frame({$urandom, $urandom}, 12, 0);
        run_frame({$urandom, $urandom}, 1, 0);
        run_frame({$urandom, $urandom}, 5, 2);
        run_frame({$urandom, $urandom}, 0, 1);

        // Randomized frames with random gaps and occasional dropped ticks.
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 1) != 0) ? 16'sd32767 : -16'sd32768;
            else if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 256; i++) mem[i] = SW'($urandom);
            n   = $urandom_range(0, 15);
            vc0 = (n > 0) ? ((n > 8) ? 8 : n) + 3 : 2;
            run_frame({$urandom, $urandom}, n,
                      ($urandom_range(0, 1) != 0) ? $urandom_range(1, vc0 - 1) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
